// File: rtl/sirc_param_regfile_if.sv
// Host-link and user-side signal bundle for the SIRC parameter register file.
// The slave modport is the register file; the master side is host link plus user circuit.
interface sirc_param_regfile_if #(
    parameter int REG_ADDRESS_WIDTH = 8
);
    logic                         hostRegWriteEn;
    logic [REG_ADDRESS_WIDTH-1:0] hostRegAddress;
    logic [31:0]                  hostRegWriteData;
    logic                         hostRunSet;
    logic                         hostRunValue;
    logic                         userRunValue;
    logic                         userRunClear;
    logic                         register32CmdReq;
    logic                         register32CmdAck;
    logic [7:0]                   register32Address;
    logic                         register32WriteEn;
    logic [31:0]                  register32WriteData;
    logic                         register32ReadDataValid;
    logic [31:0]                  register32ReadData;

    modport slave (
        input  hostRegWriteEn, hostRegAddress, hostRegWriteData, hostRunSet,
        input  userRunClear, register32CmdReq, register32Address,
        input  register32WriteEn, register32WriteData,
        output hostRunValue, userRunValue, register32CmdAck,
        output register32ReadDataValid, register32ReadData
    );

    modport master (
        output hostRegWriteEn, hostRegAddress, hostRegWriteData, hostRunSet,
        output userRunClear, register32CmdReq, register32Address,
        output register32WriteEn, register32WriteData,
        input  hostRunValue, userRunValue, register32CmdAck,
        input  register32ReadDataValid, register32ReadData
    );
endinterface

// File: rtl/sirc_param_regfile.sv
// SIRC parameter register file and run register: host writes win over user
// commands; user reads return registered data one cycle after acceptance.
module sirc_param_regfile #(
    parameter int REG_ADDRESS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sirc_param_regfile_if.slave   bus
);
    localparam int DEPTH = 1 << REG_ADDRESS_WIDTH;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RETURN = 1'b1;

    logic [31:0]                  mem_q [DEPTH];
    logic [REG_ADDRESS_WIDTH-1:0] user_addr;
    logic                         cmd_ack;
    logic                         rd_accept;
    logic                         wr_accept;

    logic [0:0]  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        run_q, run_d;

    // Upper user address bits are dropped, so user addresses wrap over the array.
    assign user_addr = bus.register32Address[REG_ADDRESS_WIDTH-1:0];
    assign cmd_ack   = bus.register32CmdReq & ~bus.hostRegWriteEn;
    assign rd_accept = cmd_ack & ~bus.register32WriteEn;
    assign wr_accept = cmd_ack &  bus.register32WriteEn;

    // NOTE: the array has no reset so it can map onto block RAM; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (bus.hostRegWriteEn) begin
            mem_q[bus.hostRegAddress] <= bus.hostRegWriteData;
        end else if (wr_accept) begin
            mem_q[user_addr] <= bus.register32WriteData;
        end
    end

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d = ST_IDLE;
        rdata_d = rdata_q;
        run_d   = run_q;
        if (rd_accept) begin
            state_d = ST_RETURN;
            rdata_d = mem_q[user_addr];
        end
        if (bus.hostRunSet) begin
            run_d = 1'b1;
        end else if (bus.userRunClear) begin
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            run_q   <= run_d;
        end
    end

    assign bus.register32CmdAck        = cmd_ack;
    assign bus.register32ReadDataValid = (state_q == ST_RETURN);
    assign bus.register32ReadData      = rdata_q;
    assign bus.userRunValue            = run_q;
    assign bus.hostRunValue            = run_q;
endmodule
